// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: core-side controller for one bank of tri-state IO pads.
// Holds the OUT/OE pad drive registers. Also brings the asynchronous pad
// inputs through a synchroniser and an optional debounce filter. Filtered
// edges latch pending interrupt bits, which are cleared by writing 1.
module gpio_pad_ctrl #(
    parameter int NPIN = 8,
    parameter int DBW  = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            wr_en_i,
    input  logic            rd_en_i,
    input  logic [2:0]      addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o,
    output logic [NPIN-1:0] gpio_out_o,
    output logic [NPIN-1:0] gpio_oe_o,
    input  logic [NPIN-1:0] gpio_in_i,
    output logic            irq_o
);

    localparam logic [DBW-1:0] CNT_ZERO = {DBW{1'b0}};
    localparam logic [DBW-1:0] CNT_ONE  = {{(DBW-1){1'b0}}, 1'b1};

    logic [NPIN-1:0]      out_r;
    logic [NPIN-1:0]      oe_r;
    logic [NPIN-1:0]      rise_en_r;
    logic [NPIN-1:0]      fall_en_r;
    logic [NPIN-1:0]      pend_r;
    logic [DBW-1:0]       db_div_r;
    logic [DBW-1:0]       cnt_r;
    logic [NPIN-1:0]      sync1_r;
    logic [NPIN-1:0]      sync2_r;
    logic [NPIN-1:0][2:0] hist_r;
    logic [NPIN-1:0]      filt_r;
    logic [NPIN-1:0]      filt_d_r;
    logic [31:0]          rdata_r;

    logic [NPIN-1:0]      wdata_pin_s;
    logic                 db_wr_s;
    logic                 bypass_s;
    logic                 tick_s;
    logic [NPIN-1:0]      filt_nxt_s;
    logic [NPIN-1:0]      edge_s;
    logic [NPIN-1:0]      clr_s;
    logic [31:0]          rd_mux_s;
    logic                 unused_wdata_s;

    assign wdata_pin_s    = wdata_i[NPIN-1:0];
    assign unused_wdata_s = ^wdata_i;
    assign db_wr_s        = wr_en_i && (addr_i == 3'd6);
    assign bypass_s       = (db_div_r == CNT_ZERO);
    // In bypass every cycle is a tick. The history then tracks the pin, so
    // enabling debounce later starts from a consistent history.
    assign tick_s         = bypass_s || (cnt_r == db_div_r);
    assign edge_s         = (filt_r & ~filt_d_r & rise_en_r) |
                            (~filt_r & filt_d_r & fall_en_r);
    assign clr_s          = (wr_en_i && (addr_i == 3'd5)) ? wdata_pin_s : {NPIN{1'b0}};

    assign gpio_out_o = out_r;
    assign gpio_oe_o  = oe_r;
    assign rdata_o    = rdata_r;
    assign irq_o      = |pend_r;

    // Plain read/write control registers, loaded on the write strobe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_r     <= {NPIN{1'b0}};
            oe_r      <= {NPIN{1'b0}};
            rise_en_r <= {NPIN{1'b0}};
            fall_en_r <= {NPIN{1'b0}};
            db_div_r  <= CNT_ZERO;
        end else if (wr_en_i) begin
            case (addr_i)
                3'd0:    out_r     <= wdata_pin_s;
                3'd1:    oe_r      <= wdata_pin_s;
                3'd3:    rise_en_r <= wdata_pin_s;
                3'd4:    fall_en_r <= wdata_pin_s;
                3'd6:    db_div_r  <= wdata_i[DBW-1:0];
                default: ;
            endcase
        end
    end

    // Pending bits: a new edge wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_r <= {NPIN{1'b0}};
        end else begin
            pend_r <= (pend_r & ~clr_s) | edge_s;
        end
    end

    // Shared debounce prescaler counting 0..DB_DIV; restarts on a DB_DIV write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r <= CNT_ZERO;
        end else if (db_wr_s || tick_s) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Input path: two-flop synchroniser, sample history, filter and delayed copy.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_r  <= {NPIN{1'b0}};
            sync2_r  <= {NPIN{1'b0}};
            hist_r   <= {NPIN{3'b000}};
            filt_r   <= {NPIN{1'b0}};
            filt_d_r <= {NPIN{1'b0}};
        end else begin
            sync1_r  <= gpio_in_i;
            sync2_r  <= sync1_r;
            filt_r   <= filt_nxt_s;
            filt_d_r <= filt_r;
            if (tick_s) begin
                for (int i = 0; i < NPIN; i++) begin
                    hist_r[i] <= {hist_r[i][1:0], sync2_r[i]};
                end
            end else begin
                hist_r <= hist_r;
            end
        end
    end

    // Filter decision: follow the synchroniser in bypass, else require a stable history.
    always_comb begin
        filt_nxt_s = filt_r;
        for (int i = 0; i < NPIN; i++) begin
            if (bypass_s) begin
                filt_nxt_s[i] = sync2_r[i];
            end else if (hist_r[i] == 3'b111) begin
                filt_nxt_s[i] = 1'b1;
            end else if (hist_r[i] == 3'b000) begin
                filt_nxt_s[i] = 1'b0;
            end else begin
                filt_nxt_s[i] = filt_r[i];
            end
        end
    end

    // Read data selection, zero-extended to the bus width.
    always_comb begin
        rd_mux_s = 32'd0;
        case (addr_i)
            3'd0:    rd_mux_s[NPIN-1:0] = out_r;
            3'd1:    rd_mux_s[NPIN-1:0] = oe_r;
            3'd2:    rd_mux_s[NPIN-1:0] = filt_r;
            3'd3:    rd_mux_s[NPIN-1:0] = rise_en_r;
            3'd4:    rd_mux_s[NPIN-1:0] = fall_en_r;
            3'd5:    rd_mux_s[NPIN-1:0] = pend_r;
            3'd6:    rd_mux_s[DBW-1:0]  = db_div_r;
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Registered read data, held until the next read strobe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_r <= 32'd0;
        end else if (rd_en_i) begin
            rdata_r <= rd_mux_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed self-checking bench for gpio_pad_ctrl (NPIN=8, DBW=16).
module tb_gpio_pad_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic [7:0]  gpio_in;
    logic        irq;

    int n_checks;
    int n_fail;

    gpio_pad_ctrl #(.NPIN(8), .DBW(16)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wr_en_i    (wr_en),
        .rd_en_i    (rd_en),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .gpio_out_o (gpio_out),
        .gpio_oe_o  (gpio_oe),
        .gpio_in_i  (gpio_in),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        @(negedge clk);
        rd_en = 1'b1;
        addr  = a;
        @(negedge clk);
        rd_en = 1'b0;
        check_val(tag, rdata, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        addr     = 3'd0;
        wdata    = 32'd0;
        gpio_in  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1. reset state
        check_val("rst_oe", {24'd0, gpio_oe}, 32'h0);
        check_val("rst_out", {24'd0, gpio_out}, 32'h0);
        check_val("rst_irq", {31'd0, irq}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd_chk($sformatf("rst_rd%0d", a), 3'(a), 32'h0);
        end

        // 2. OUT / OE writes and reads
        bus_wr(3'd0, 32'h0000_00A5);
        check_val("out_a5", {24'd0, gpio_out}, 32'hA5);
        check_val("oe_still0", {24'd0, gpio_oe}, 32'h0);
        bus_wr(3'd1, 32'h0000_000F);
        check_val("oe_0f", {24'd0, gpio_oe}, 32'h0F);
        rd_chk("rd_out", 3'd0, 32'hA5);
        repeat (3) @(negedge clk);
        check_val("rdata_hold", rdata, 32'hA5);
        @(negedge clk);
        wr_en = 1'b1;
        rd_en = 1'b1;
        addr  = 3'd0;
        wdata = 32'hFFFF_FF3C;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_val("rdwr_old", rdata, 32'hA5);
        check_val("out_upper_ign", {24'd0, gpio_out}, 32'h3C);
        bus_wr(3'd2, 32'hFF);
        rd_chk("in_ro", 3'd2, 32'h0);
        bus_wr(3'd7, 32'hFF);
        rd_chk("rd7", 3'd7, 32'h0);

        // 3. bypass filter latency and rise interrupt
        bus_wr(3'd3, 32'h01);
        gpio_in[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd_en = 1'b1;
        addr  = 3'd2;
        @(negedge clk);
        check_val("in_edge3_pre", rdata, 32'h0);
        check_val("irq_edge3", {31'd0, irq}, 32'h0);
        @(negedge clk);
        rd_en = 1'b0;
        check_val("in_edge4", rdata, 32'h1);
        check_val("irq_edge4", {31'd0, irq}, 32'h1);
        rd_chk("pend_rise0", 3'd5, 32'h01);
        bus_wr(3'd5, 32'h01);
        check_val("irq_cleared", {31'd0, irq}, 32'h0);
        rd_chk("pend_clr", 3'd5, 32'h0);

        // 4. fall on pin1 coinciding with W1C of bit1
        bus_wr(3'd4, 32'h02);
        gpio_in[1] = 1'b1;
        repeat (6) @(negedge clk);
        rd_chk("pend_no_rise1", 3'd5, 32'h0);
        gpio_in[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = 3'd5;
        wdata = 32'h02;
        @(negedge clk);
        wr_en = 1'b0;
        wdata = 32'd0;
        check_val("irq_set_wins", {31'd0, irq}, 32'h1);
        rd_chk("pend_set_wins", 3'd5, 32'h02);

        // 5. debounce with DB_DIV=9
        bus_wr(3'd6, 32'hFFFF_0009);
        rd_chk("db_div", 3'd6, 32'h9);
        gpio_in[2] = 1'b1;
        repeat (15) @(negedge clk);
        gpio_in[2] = 1'b0;
        repeat (40) @(negedge clk);
        rd_chk("glitch_rejected", 3'd2, 32'h01);
        gpio_in[2] = 1'b1;
        repeat (10) @(negedge clk);
        rd_chk("db_not_yet", 3'd2, 32'h01);
        repeat (20) @(negedge clk);
        rd_chk("db_settled", 3'd2, 32'h05);

        // 6. async reset in the middle of debouncing pin3
        bus_wr(3'd3, 32'h08);
        gpio_in[3] = 1'b1;
        repeat (8) @(negedge clk);
        check_val("irq_pre_rst", {31'd0, irq}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_out", {24'd0, gpio_out}, 32'h0);
        check_val("arst_oe", {24'd0, gpio_oe}, 32'h0);
        check_val("arst_irq", {31'd0, irq}, 32'h0);
        check_val("arst_rdata", rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus_wr(3'd3, 32'h08);
        repeat (2) @(negedge clk);
        rd_chk("post_rst_pend", 3'd5, 32'h08);
        check_val("post_rst_irq", {31'd0, irq}, 32'h1);
        rd_chk("post_rst_db0", 3'd6, 32'h0);
        bus_wr(3'd5, 32'h08);
        repeat (10) @(negedge clk);
        rd_chk("single_rise", 3'd5, 32'h0);
        check_val("final_irq", {31'd0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
